// File: rtl/display_dma_pixel_unpack.sv
// display_dma_pixel_unpack
//   Unpacks 64-bit display DMA beats, each carrying two XRGB8888 pixels, into a
//   stream of 24-bit RGB pixels at one pixel per clock. Each pixel is tagged
//   with start/end-of-frame and start/end-of-line markers derived from
//   active-area x/y counters. Debug status words are kept for APB readback.
//
// Ports
//   clk, rst             display pixel clock; synchronous active-high reset
//   frame_restart        1-cycle pulse: flush both stages and zero x/y
//   display_dma_rdata    beat data: [31:0] pixel 0, [63:32] pixel 1 (byte 3 of each unused)
//   display_dma_rkeep    byte enables: [3:0] lane 0, [7:4] lane 1
//   display_dma_rvalid   beat valid
//   display_dma_rready   beat accepted when rvalid & rready
//   pix_data             {R,G,B}
//   pix_valid            pixel valid
//   pix_ready            downstream accepts when pix_valid & pix_ready
//   pix_sof/sol/eol/eof  position markers, qualified by pix_valid
//   status               {keep_err, 7'b0, y[11:0], x[11:0]} of the next pixel to load
//   uflow_cnt            saturating count of starved cycles inside a frame
module display_dma_pixel_unpack #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int UFLOW_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_restart,
  input  logic [63:0]        display_dma_rdata,
  input  logic [7:0]         display_dma_rkeep,
  input  logic               display_dma_rvalid,
  output logic               display_dma_rready,
  output logic [23:0]        pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_sof,
  output logic               pix_sol,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic [31:0]        status,
  output logic [UFLOW_W-1:0] uflow_cnt
);

  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);

  // A keep nibble is only meaningful as all-off or all-on.
  function automatic logic nib_bad(input logic [3:0] n);
    return (n != 4'h0) && (n != 4'hF);
  endfunction

  function automatic logic [UFLOW_W-1:0] sat_inc(input logic [UFLOW_W-1:0] v);
    return (&v) ? v : v + {{(UFLOW_W-1){1'b0}}, 1'b1};
  endfunction

  logic [23:0]        lane0_q, lane1_q;
  logic [1:0]         lane_vld_q, lane_vld_d;
  logic               keep_err_q;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic               pix_valid_q;
  logic [23:0]        pix_data_q;
  logic               sof_q, sol_q, eol_q, eof_q;
  logic [UFLOW_W-1:0] uflow_q;

  logic               beat_full, s2_load, move, last_lane, accept, beat_bad;
  logic [23:0]        lane_px;
  logic [1:0]         new_vld;
  logic               unused_bits;

  assign unused_bits = ^{display_dma_rdata[63:56], display_dma_rdata[31:24]};

  always_comb begin
    beat_full = |lane_vld_q;
    s2_load   = !pix_valid_q || pix_ready;
    move      = beat_full && s2_load;
    // Only one lane left means the beat register empties this cycle, so a new
    // beat can be taken in the same cycle for back-to-back throughput.
    last_lane = (lane_vld_q != 2'b11);
    lane_px   = lane_vld_q[0] ? lane0_q : lane1_q;

    display_dma_rready = !rst && !frame_restart && (!beat_full || (move && last_lane));
    accept   = display_dma_rvalid && display_dma_rready;
    new_vld  = {&display_dma_rkeep[7:4], &display_dma_rkeep[3:0]};
    beat_bad = nib_bad(display_dma_rkeep[7:4]) || nib_bad(display_dma_rkeep[3:0]);

    lane_vld_d = lane_vld_q;
    if (move) lane_vld_d = lane_vld_q[0] ? {lane_vld_q[1], 1'b0} : 2'b00;
    if (accept) lane_vld_d = new_vld;

    x_d = (x_q == X_LAST) ? 12'd0 : x_q + 12'd1;
    y_d = y_q;
    if (x_q == X_LAST) y_d = (y_q == Y_LAST) ? 12'd0 : y_q + 12'd1;
  end

  // ---- stage 1: beat register ----
  always_ff @(posedge clk) begin
    if (rst || frame_restart) lane_vld_q <= 2'b00;
    else                      lane_vld_q <= lane_vld_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lane0_q <= display_dma_rdata[23:0];
      lane1_q <= display_dma_rdata[55:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      keep_err_q <= 1'b0;
    else if (accept && beat_bad)  keep_err_q <= 1'b1;
  end

  // ---- stage 2: output register and position counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_data_q  <= 24'd0;
      {sof_q, sol_q, eol_q, eof_q} <= 4'b0;
      x_q <= 12'd0;
      y_q <= 12'd0;
    end else if (frame_restart) begin
      pix_valid_q <= 1'b0;
      {sof_q, sol_q, eol_q, eof_q} <= 4'b0;
      x_q <= 12'd0;
      y_q <= 12'd0;
    end else if (s2_load) begin
      pix_valid_q <= move;
      if (move) begin
        pix_data_q <= lane_px;
        sol_q <= (x_q == 12'd0);
        eol_q <= (x_q == X_LAST);
        sof_q <= (x_q == 12'd0) && (y_q == 12'd0);
        eof_q <= (x_q == X_LAST) && (y_q == Y_LAST);
        x_q   <= x_d;
        y_q   <= y_d;
      end
    end
  end

  // Starvation is only counted once the frame has started, i.e. away from
  // the origin where an idle link is expected.
  always_ff @(posedge clk) begin
    if (rst)
      uflow_q <= '0;
    else if (pix_ready && !pix_valid_q && !((x_q == 12'd0) && (y_q == 12'd0)))
      uflow_q <= sat_inc(uflow_q);
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_sof   = sof_q;
  assign pix_sol   = sol_q;
  assign pix_eol   = eol_q;
  assign pix_eof   = eof_q;
  assign status    = {keep_err_q, 7'b0, y_q, x_q};
  assign uflow_cnt = uflow_q;

endmodule

// File: tb/tb_display_dma_pixel_unpack.sv
// tb_display_dma_pixel_unpack
//   Drives two instances of display_dma_pixel_unpack from the same stimulus:
//   one with the full 1280x720 raster and 16-bit underflow counter, one with a
//   tiny 4x3 raster and 2-bit counter so frame wraps and saturation occur
//   quickly. A reference model tracks accepted lanes as an ordered pixel list
//   and derives markers/status from pixel indices.
module tb_display_dma_pixel_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_restart = 1'b0;
  logic [63:0] rdata = 64'd0;
  logic [7:0]  rkeep = 8'd0;
  logic        rvalid = 1'b0;
  logic        pix_ready = 1'b0;

  logic        rready_w[2], pv_w[2], sof_w[2], sol_w[2], eol_w[2], eof_w[2];
  logic [23:0] pd_w[2];
  logic [31:0] st_w[2];
  logic [15:0] uf_a;
  logic [1:0]  uf_b;

  always #5 clk = ~clk;

  display_dma_pixel_unpack #(.H_ACTIVE(1280), .V_ACTIVE(720), .UFLOW_W(16)) dut_a (
    .clk(clk), .rst(rst), .frame_restart(frame_restart),
    .display_dma_rdata(rdata), .display_dma_rkeep(rkeep), .display_dma_rvalid(rvalid),
    .display_dma_rready(rready_w[0]), .pix_data(pd_w[0]), .pix_valid(pv_w[0]),
    .pix_ready(pix_ready), .pix_sof(sof_w[0]), .pix_sol(sol_w[0]), .pix_eol(eol_w[0]),
    .pix_eof(eof_w[0]), .status(st_w[0]), .uflow_cnt(uf_a));

  display_dma_pixel_unpack #(.H_ACTIVE(4), .V_ACTIVE(3), .UFLOW_W(2)) dut_b (
    .clk(clk), .rst(rst), .frame_restart(frame_restart),
    .display_dma_rdata(rdata), .display_dma_rkeep(rkeep), .display_dma_rvalid(rvalid),
    .display_dma_rready(rready_w[1]), .pix_data(pd_w[1]), .pix_valid(pv_w[1]),
    .pix_ready(pix_ready), .pix_sof(sof_w[1]), .pix_sol(sol_w[1]), .pix_eol(eol_w[1]),
    .pix_eof(eof_w[1]), .status(st_w[1]), .uflow_cnt(uf_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned Hm[2], Vm[2], ufmax[2];
  int unsigned idx[2], ufm[2], rd[2], wr[2];
  bit          kerr[2], stall[2];
  logic [23:0] fifo[2][16];
  logic [23:0] pdprev[2];
  int unsigned fr_m, ld_m, px_m, py_m;
  logic [31:0] est_m;

  int cyc = 0;
  int hs_cnt, first_hs, last_hs, nrdy, hs_total = 0;
  logic [1:0] m0;
  logic eol1279;
  int rmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        idx[i] = 0; ufm[i] = 0; rd[i] = 0; wr[i] = 0; kerr[i] = 0; stall[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fr_m  = Hm[i] * Vm[i];
        ld_m  = (idx[i] + (pv_w[i] ? 1 : 0)) % fr_m;
        est_m = {kerr[i], 7'b0, 12'(ld_m / Hm[i]), 12'(ld_m % Hm[i])};
        chk("status", st_w[i], est_m);
        chk("uflow_cnt", (i == 0) ? 64'(uf_a) : 64'(uf_b), ufm[i]);
        if (pv_w[i]) begin
          if (stall[i]) chk("hold_data", pd_w[i], pdprev[i]);
          chk("pixel_expected", (wr[i] - rd[i]) > 0, 1'b1);
          if (wr[i] != rd[i]) begin
            px_m = idx[i] % Hm[i];
            py_m = (idx[i] / Hm[i]) % Vm[i];
            chk("pix_data", pd_w[i], fifo[i][rd[i] % 16]);
            chk("pix_sol", sol_w[i], px_m == 0);
            chk("pix_eol", eol_w[i], px_m == Hm[i] - 1);
            chk("pix_sof", sof_w[i], (px_m == 0) && (py_m == 0));
            chk("pix_eof", eof_w[i], (px_m == Hm[i] - 1) && (py_m == Vm[i] - 1));
          end
        end
        // state change at the coming clock edge
        if (pix_ready && !pv_w[i] && (idx[i] % fr_m != 0) && ufm[i] < ufmax[i]) ufm[i]++;
        if (frame_restart) begin
          chk("rready_on_restart", rready_w[i], 1'b0);
          rd[i] = wr[i]; idx[i] = 0; stall[i] = 0;
        end else begin
          if (pv_w[i] && pix_ready && wr[i] != rd[i]) begin
            rd[i]++;
            idx[i] = (idx[i] + 1) % fr_m;
            if (i == 0) begin
              if (hs_cnt == 0) begin first_hs = cyc; m0 = {sof_w[0], sol_w[0]}; end
              if (hs_cnt == 1279) eol1279 = eol_w[0];
              last_hs = cyc;
              hs_cnt++;
              hs_total++;
            end
          end
          if (rvalid && rready_w[i]) begin
            if (rkeep[3:0] == 4'hF) begin fifo[i][wr[i] % 16] = rdata[23:0];  wr[i]++; end
            if (rkeep[7:4] == 4'hF) begin fifo[i][wr[i] % 16] = rdata[55:32]; wr[i]++; end
            if (!(rkeep[3:0] inside {4'h0, 4'hF}) || !(rkeep[7:4] inside {4'h0, 4'hF})) kerr[i] = 1;
          end
          stall[i] = pv_w[i] && !pix_ready;
          if (i == 0 && rvalid && !rready_w[0]) nrdy++;
        end
        pdprev[i] = pd_w[i];
      end
    end
  end

  // pix_ready pattern generator: 1 = toggle each cycle, 2 = random (75% ready)
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode == 1) pix_ready = ~pix_ready;
      else if (rmode == 2) pix_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_cyc;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_stats();
    hs_cnt = 0; nrdy = 0; first_hs = 0; last_hs = 0; m0 = 2'b00; eol1279 = 1'b0;
  endtask

  task automatic do_reset();
    rvalid = 0; frame_restart = 0; rst = 1;
    tick();
    @(negedge clk);
    chk("rready_during_rst", rready_w[0], 1'b0);
    tick();
    rst = 0;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k);
    rvalid = 1; rdata = d; rkeep = k;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rready_w[0]) begin
        acc_cyc = cyc;
        tick();
        rvalid = 0;
        return;
      end
    end
    chk("send_timeout_rready", rready_w[0], 1'b1);
    rvalid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #2;
      if (wr[0] == rd[0] && wr[1] == rd[1]) return;
    end
    chk("drain_timeout_pending", 64'(wr[0] - rd[0]), 64'd0);
  endtask

  function automatic logic [7:0] pick_keep();
    case ($urandom_range(0, 5))
      0, 1:    return 8'hFF;
      2:       return 8'h0F;
      3:       return 8'hF0;
      4:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  int a0, a_last;

  initial begin
    Hm = '{1280, 4}; Vm = '{720, 3}; ufmax = '{65535, 3};
    reset_stats();

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_rready", rready_w[0], 1'b1);
    chk("rst_pix_valid", pv_w[0], 1'b0);
    chk("rst_pix_data", pd_w[0], 24'd0);
    chk("rst_markers", {sof_w[0], sol_w[0], eol_w[0], eof_w[0]}, 4'b0);
    chk("rst_status", st_w[0], 32'd0);
    chk("rst_uflow", uf_a, 16'd0);

    // full line of back-to-back beats
    tick();
    pix_ready = 1; reset_stats();
    for (int b = 0; b < 640; b++) begin
      send({$urandom, $urandom}, 8'hFF);
      if (b == 0) a0 = acc_cyc;
    end
    a_last = acc_cyc;
    drain();
    chk("t1_accept_spacing", 64'(a_last - a0), 64'd1278);
    chk("t1_pixel_count", 64'(hs_cnt), 64'd1280);
    chk("t1_back_to_back", 64'(last_hs - first_hs), 64'd1279);
    chk("t1_latency", 64'(first_hs - a0), 64'd2);
    chk("t1_first_sof_sol", m0, 2'b11);
    chk("t1_eol_pixel_1279", eol1279, 1'b1);

    // lane order and data
    do_reset();
    pix_ready = 1;
    rvalid = 1; rdata = 64'h00AABBCC_00112233; rkeep = 8'hFF;
    @(negedge clk);
    chk("t2_rready", rready_w[0], 1'b1);
    tick(); rvalid = 0;
    @(negedge clk);
    chk("t2_valid_n1", pv_w[0], 1'b0);
    tick();
    @(negedge clk);
    chk("t2_valid_n2", pv_w[0], 1'b1);
    chk("t2_pixel0", pd_w[0], 24'h112233);
    tick();
    @(negedge clk);
    chk("t2_pixel1", pd_w[0], 24'hAABBCC);
    tick();

    // alternating pix_ready back-pressure
    do_reset();
    reset_stats(); rmode = 1;
    for (int b = 0; b < 20; b++) send({$urandom, $urandom}, 8'hFF);
    drain();
    rmode = 0; pix_ready = 1;
    chk("t3_pixel_count", 64'(hs_cnt), 64'd40);
    chk("t3_rready_backpressure", nrdy != 0, 1'b1);

    // partial keeps
    do_reset();
    pix_ready = 1; reset_stats();
    send(64'h00A1A2A3_00B1B2B3, 8'h0F);
    send(64'h00C1C2C3_00D1D2D3, 8'h00);
    send(64'h00E1E2E3_00F1F2F3, 8'hF0);
    drain();
    chk("t4_keep_err_clean", st_w[0][31], 1'b0);
    send(64'h00112233_00445566, 8'h3F);
    drain();
    chk("t4_pixel_count", 64'(hs_cnt), 64'd3);
    chk("t4_keep_err_set", st_w[0][31], 1'b1);

    // frame_restart mid-line
    do_reset();
    pix_ready = 1;
    for (int b = 0; b < 3; b++) send({$urandom, $urandom}, 8'hFF);
    tick();
    frame_restart = 1; rvalid = 1; rdata = {$urandom, $urandom}; rkeep = 8'hFF;
    @(negedge clk);
    chk("t5_rready_blocked", rready_w[0], 1'b0);
    tick();
    frame_restart = 0;
    @(negedge clk);
    chk("t5_status_pos", st_w[0][23:0], 24'd0);
    chk("t5_valid_cleared", pv_w[0], 1'b0);
    tick();
    rvalid = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (pv_w[0]) break;
    end
    chk("t5_next_sof", sof_w[0], 1'b1);
    drain();

    // underflow count and saturation
    do_reset();
    pix_ready = 0;
    send(64'h00010203_00040506, 8'hFF);
    tick(); tick();
    pix_ready = 1;
    repeat (7) tick();
    pix_ready = 0;
    @(negedge clk);
    chk("t6_uflow_5", uf_a, 16'd5);
    chk("t6_uflow_sat", uf_b, 2'd3);
    tick();

    // randomized traffic
    do_reset();
    rmode = 2;
    for (int it = 0; it < 2500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) send({$urandom, $urandom}, pick_keep());
      else if (r < 95) tick();
      else if (r < 98) begin frame_restart = 1; tick(); frame_restart = 0; end
      else do_reset();
    end
    drain();
    rmode = 0; pix_ready = 1;
    tick();
    chk("rand_traffic_flowed", hs_total > 500, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
